// File: rtl/fpu_pkg.sv
// Shared constants and types for the FPU operand path.
// Operand word layout: sign [31], exponent [30:22], mantissa [21:0].
package fpu_pkg;

  localparam int unsigned EXP_W    = 9;
  localparam int unsigned MAN_W    = 22;
  localparam int unsigned SIGN_BIT = 31;

  localparam int unsigned EXP_MSB = 30;
  localparam int unsigned EXP_LSB = 22;
  localparam int unsigned MAN_MSB = 21;
  localparam int unsigned MAN_LSB = 0;
  // Magnitude (exponent + mantissa) excluding the sign bit.
  localparam int unsigned MAG_MSB = 30;

  typedef enum logic [1:0] {
    StIdle,
    StWaitB,
    StHold,
    StDone
  } loader_state_e;

  // Unsigned absolute difference of two biased exponents.
  function automatic logic [EXP_W-1:0] exp_abs_diff(input logic [EXP_W-1:0] a,
                                                    input logic [EXP_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/fpu_operand_classify.sv
// Combinational operand classifier: per-operand zero detect and |expA - expB|.
module fpu_operand_classify
  import fpu_pkg::*;
(
  input  logic [31:0]      i_op_a,
  input  logic [31:0]      i_op_b,
  output logic [1:0]       o_zero_flags,
  output logic [EXP_W-1:0] o_exp_diff
);

  // Sign is ignored: +0 and -0 both count as zero.
  always_comb begin
    o_zero_flags[0] = (i_op_a[MAG_MSB:0] == '0);
    o_zero_flags[1] = (i_op_b[MAG_MSB:0] == '0);
    o_exp_diff      = exp_abs_diff(i_op_a[EXP_MSB:EXP_LSB], i_op_b[EXP_MSB:EXP_LSB]);
  end

endmodule

// File: rtl/fpu_operand_loader.sv
// Collects two operand words (A then B) and holds them stable for the
// downstream adder for HOLD_CYCLES cycles, then pulses o_done.
// Optional feature macro: FPU_LOADER_ZERO_SHORTCUT_EN shortens the hold to
// 2 cycles when either operand is zero.
module fpu_operand_loader
  import fpu_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 540
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [31:0]      i_data,
  output logic             o_ready,
  output logic [31:0]      o_op_a,
  output logic [31:0]      o_op_b,
  output logic             o_ops_valid,
  output logic [1:0]       o_zero_flags,
  output logic [EXP_W-1:0] o_exp_diff,
  output logic             o_done
);

  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES) + 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  if (HOLD_CYCLES < 2) begin : g_bad_hold
    $error("fpu_operand_loader: HOLD_CYCLES must be at least 2");
  end

  loader_state_e    r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_op_a;
  logic [31:0]      r_op_b;
  logic             r_ops_valid;
  logic [1:0]       r_zero_flags;
  logic [EXP_W-1:0] r_exp_diff;
  logic             r_done;

  logic [1:0]       w_zero_flags;
  logic [EXP_W-1:0] w_exp_diff;
  logic [CNT_W-1:0] w_cnt_load;

  // Classify the captured A against the incoming word, which is B on capture.
  fpu_operand_classify u_classify (
    .i_op_a       (r_op_a),
    .i_op_b       (i_data),
    .o_zero_flags (w_zero_flags),
    .o_exp_diff   (w_exp_diff)
  );

  // Hold length: zero operands resolve in the adder's INIT step when enabled.
`ifdef FPU_LOADER_ZERO_SHORTCUT_EN
  assign w_cnt_load = (|w_zero_flags) ? CNT_W'(1) : HOLD_LOAD;
`else
  assign w_cnt_load = HOLD_LOAD;
`endif

  // Loader FSM with registered outputs; counter value N leaves N+1 HOLD cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_ops_valid  <= 1'b0;
      r_zero_flags <= '0;
      r_exp_diff   <= '0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_valid) begin
            r_op_a  <= i_data;
            r_state <= StWaitB;
          end
        end
        StWaitB: begin
          if (i_valid) begin
            r_op_b       <= i_data;
            r_zero_flags <= w_zero_flags;
            r_exp_diff   <= w_exp_diff;
            r_cnt        <= w_cnt_load;
            r_ops_valid  <= 1'b1;
            r_state      <= StHold;
          end
        end
        StHold: begin
          if (r_cnt == '0) begin
            r_ops_valid <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= StDone;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_ready      = (r_state == StIdle) || (r_state == StWaitB);
  assign o_op_a       = r_op_a;
  assign o_op_b       = r_op_b;
  assign o_ops_valid  = r_ops_valid;
  assign o_zero_flags = r_zero_flags;
  assign o_exp_diff   = r_exp_diff;
  assign o_done       = r_done;

endmodule

// File: tb/tb_fpu_operand_loader.sv
// Directed self-checking bench for fpu_operand_loader (default HOLD_CYCLES).
module tb_fpu_operand_loader;

  localparam int unsigned HOLD = 540;
`ifdef FPU_LOADER_ZERO_SHORTCUT_EN
  localparam int unsigned ZERO_HOLD = 2;
`else
  localparam int unsigned ZERO_HOLD = HOLD;
`endif

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [31:0] data;
  logic        ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        ops_valid;
  logic [1:0]  zero_flags;
  logic [8:0]  exp_diff;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  fpu_operand_loader #(.HOLD_CYCLES(HOLD)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (valid),
    .i_data       (data),
    .o_ready      (ready),
    .o_op_a       (op_a),
    .o_op_b       (op_b),
    .o_ops_valid  (ops_valid),
    .o_zero_flags (zero_flags),
    .o_exp_diff   (exp_diff),
    .o_done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one word with valid high; sample just after the capturing edge.
  task automatic send(input logic [31:0] d);
    @(negedge clk);
    valid = 1'b1;
    data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic load_pair(input string tag, input logic [31:0] a, input logic [31:0] b);
    send(a);
    check({tag, "_a"}, op_a, a);
    check({tag, "_ready_wb"}, {31'd0, ready}, 32'd1);
    send(b);
    check({tag, "_b"}, op_b, b);
  endtask

  // Runs from just after B capture to IDLE, scrambling i_data with valid high.
  task automatic run_hold(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int unsigned exp_len, input logic [8:0] exp_d,
                          input logic [1:0] exp_z);
    int  hi;
    int  dn;
    int  bad;
    bit  fin;
    hi  = 0;
    dn  = 0;
    bad = 0;
    fin = 1'b0;
    check({tag, "_ops_valid"}, {31'd0, ops_valid}, 32'd1);
    check({tag, "_exp_diff"}, {23'd0, exp_diff}, {23'd0, exp_d});
    check({tag, "_zero"}, {30'd0, zero_flags}, {30'd0, exp_z});
    check({tag, "_ready_hold"}, {31'd0, ready}, 32'd0);
    if (ops_valid) hi++;
    for (int i = 0; i < 2000 && !fin; i++) begin
      @(negedge clk);
      valid = 1'b1;
      data  = $urandom;
      @(posedge clk);
      #1;
      if (ops_valid) hi++;
      if (op_a !== a || op_b !== b) bad++;
      if (ready) bad++;
      if (done) begin
        dn++;
        fin = 1'b1;
      end
    end
    check({tag, "_hold_len"}, hi, exp_len);
    check({tag, "_done_cnt"}, dn, 32'd1);
    check({tag, "_stable"}, bad, 32'd0);
    @(negedge clk);
    valid = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_done_end"}, {31'd0, done}, 32'd0);
    check({tag, "_ready_idle"}, {31'd0, ready}, 32'd1);
    check({tag, "_a_kept"}, op_a, a);
  endtask

  initial begin
    int dn;
    rst_n = 1'b0;
    valid = 1'b0;
    data  = '0;
    #1;
    check("rst_op_a", op_a, 32'd0);
    check("rst_op_b", op_b, 32'd0);
    check("rst_ops_valid", {31'd0, ops_valid}, 32'd0);
    check("rst_zero", {30'd0, zero_flags}, 32'd0);
    check("rst_diff", {23'd0, exp_diff}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    #24;
    rst_n = 1'b1;
    #1;
    check("rst_ready", {31'd0, ready}, 32'd1);

    // Basic pair: exponents 0xFF and 0x100.
    load_pair("basic", 32'h3FC0_0000, 32'h4000_0000);
    run_hold("basic", 32'h3FC0_0000, 32'h4000_0000, HOLD, 9'd1, 2'b00);

    // Zero A operand.
    load_pair("zero", 32'h0000_0000, 32'h4040_0000);
    run_hold("zero", 32'h0000_0000, 32'h4040_0000, ZERO_HOLD, 9'h101, 2'b01);

    // Extreme exponents, both orders.
    load_pair("ext1", 32'h0000_0001, 32'h7FC0_0000);
    run_hold("ext1", 32'h0000_0001, 32'h7FC0_0000, HOLD, 9'h1FF, 2'b00);
    load_pair("ext2", 32'h7FC0_0000, 32'h8000_0001);
    run_hold("ext2", 32'h7FC0_0000, 32'h8000_0001, HOLD, 9'h1FF, 2'b00);

    // Reset 100 cycles into HOLD.
    load_pair("rst_mid", 32'h3F80_0000, 32'h4120_0000);
    valid = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstm_op_a", op_a, 32'd0);
    check("rstm_op_b", op_b, 32'd0);
    check("rstm_ops_valid", {31'd0, ops_valid}, 32'd0);
    check("rstm_zero", {30'd0, zero_flags}, 32'd0);
    check("rstm_diff", {23'd0, exp_diff}, 32'd0);
    check("rstm_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    check("rstm_no_done", dn, 32'd0);
    send(32'h1234_5678);
    check("rstm_new_a", op_a, 32'h1234_5678);
    check("rstm_b_clear", op_b, 32'd0);

    // Stall in WAIT_B for 10 cycles, then complete the pair.
    @(negedge clk);
    valid = 1'b0;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (ops_valid || !ready || op_b !== 32'd0) dn++;
    end
    check("stall_wait_b", dn, 32'd0);
    send(32'h1234_0000);
    check("stall_b", op_b, 32'h1234_0000);
    // Both exponents are 0x048.
    run_hold("stall", 32'h1234_5678, 32'h1234_0000, HOLD, 9'd0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so a stuck FSM still reaches a verdict.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fpu_operand_loader.md
FPU_OPERAND_LOADER -- requirements
Module: fpu_operand_loader

Interface
REQ-001 Parameter HOLD_CYCLES, default 540, cycles operands are held stable for the downstream adder (covers 511 alignment shifts + 23 normalise shifts + INIT/SUM).
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-low reset; 0 resets the block immediately.
REQ-004 in_valid  input  1  upstream word present on in_data.
REQ-005 in_data  input  32  operand word: sign [31], exponent [30:22], mantissa [21:0].
REQ-006 in_ready  output  1  block accepts in_data this cycle.
REQ-007 op_A_out  output  32  first operand of pair, feeds adder op_A_in.
REQ-008 op_B_out  output  32  second operand of pair, feeds adder op_B_in.
REQ-009 ops_valid  output  1  op_A_out/op_B_out form a valid pair under hold.
REQ-010 zero_flags  output  2  {B zero, A zero}; operand zero when bits [30:0] == 0.
REQ-011 exp_diff  output  9  |exponent A - exponent B|, unsigned.
REQ-012 done  output  1  one-cycle pulse: hold window ended, result may be sampled.

Function
REQ-013 States SHALL be IDLE, WAIT_B, HOLD, DONE.
REQ-014 IDLE: in_ready=1; in_valid=1 captures in_data into op_A_out -> WAIT_B.
REQ-015 WAIT_B: in_ready=1; in_valid=1 captures in_data into op_B_out, registers zero_flags and exp_diff, loads hold counter with HOLD_CYCLES-1, sets ops_valid -> HOLD.
REQ-016 HOLD: in_ready=0, in_valid ignored, op_A_out/op_B_out unchanged; counter decrements each cycle; at 0 -> DONE.
REQ-017 DONE: done=1 for exactly this cycle, ops_valid cleared, in_ready=0 -> IDLE.
REQ-018 Transfer occurs only when in_valid && in_ready on a rising edge; in_valid low in IDLE/WAIT_B holds the state indefinitely.
REQ-019 ops_valid SHALL be 1 from the cycle after B capture through the DONE cycle's predecessor; total ops_valid high time = HOLD_CYCLES cycles.
REQ-020 exp_diff computed with 9-bit operands, result never negative; equal exponents give 0.
REQ-021 Counter width SHALL be $clog2(HOLD_CYCLES)+1; HOLD_CYCLES < 2 is illegal (elaboration error).
REQ-022 Back-to-back pairs: minimum pair-to-pair interval is HOLD_CYCLES+3 cycles; op_A_out keeps old value until the next A capture.

Reset
REQ-023 reset=0 forces state IDLE, op_A_out=0, op_B_out=0, ops_valid=0, zero_flags=0, exp_diff=0, done=0, counter=0; in_ready=1 after reset release.
REQ-024 Reset asserted mid-HOLD or mid-WAIT_B SHALL discard the partial pair; no done pulse issued.

Configuration
REQ-025 Macro FPU_LOADER_ZERO_SHORTCUT_EN: when defined and either zero flag is set at B capture, the counter loads 1 (HOLD lasts 2 cycles), since the adder resolves zero operands in INIT.
REQ-026 Without FPU_LOADER_ZERO_SHORTCUT_EN, every pair is held HOLD_CYCLES cycles regardless of zero_flags.

Structure
REQ-027 Package fpu_pkg SHALL hold EXP_W=9, MAN_W=22, SIGN_BIT=31, field slice constants and the loader state enum typedef.
REQ-028 Sub-module fpu_operand_classify (combinational): inputs two 32-bit words, outputs zero_flags and exp_diff; instantiated once.

Verification
REQ-029 Reset, then A=0x3FC00000, B=0x40000000 with in_valid held -> A at edge 1, B at edge 2, exp_diff=1, zero_flags=00, ops_valid high 540 cycles, single done pulse.
REQ-030 A=0x00000000, B=0x40400000 with macro defined -> zero_flags=01, hold 2 cycles; macro undefined -> hold 540 cycles.
REQ-031 in_valid held high during HOLD with changing in_data -> in_ready=0, op_A_out/op_B_out unchanged, no extra capture.
REQ-032 reset pulsed low 100 cycles into HOLD -> all outputs 0 immediately, no done, next word captured as A.
REQ-033 A exponent 0x000, B exponent 0x1FF -> exp_diff=0x1FF; swap order -> exp_diff=0x1FF.
REQ-034 in_valid low for 10 cycles in WAIT_B -> state held, ops_valid=0, then B capture proceeds normally.
